sram_1rw1r_wmask: RTL and testbench

//  Parametrised behavioural SRAM model: one read/write port (port 0) with per-granule write mask, plus one read-only port (port 1).

---
 rtl/sram_1rw1r_wmask_if.sv | 31 +++
 rtl/sram_1rw1r_wmask.sv | 99 +++++++++
 tb/tb_sram_1rw1r_wmask.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_1rw1r_wmask_if.sv
// Command/response bundle for the 1RW+1R masked SRAM.
// Valid/ready: a command on either port is taken on a posedge only when ready0 = 1; dvalidN marks that doutN was refreshed on that edge.
interface sram_1rw1r_wmask_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int WMASK_WIDTH = 4
) ();
    logic                   ready0;
    logic                   state_dbg;
    logic                   csb0;
    logic                   web0;
    logic [WMASK_WIDTH-1:0] wmask0;
    logic [ADDR_WIDTH-1:0]  addr0;
    logic [DATA_WIDTH-1:0]  din0;
    logic [DATA_WIDTH-1:0]  dout0;
    logic                   dvalid0;
    logic                   csb1;
    logic [ADDR_WIDTH-1:0]  addr1;
    logic [DATA_WIDTH-1:0]  dout1;
    logic                   dvalid1;

    modport master (
        input  ready0, state_dbg, dout0, dvalid0, dout1, dvalid1,
        output csb0, web0, wmask0, addr0, din0, csb1, addr1
    );

    modport slave (
        output ready0, state_dbg, dout0, dvalid0, dout1, dvalid1,
        input  csb0, web0, wmask0, addr0, din0, csb1, addr1
    );
endinterface

// File: rtl/sram_1rw1r_wmask.sv
// Behavioural SRAM: port 0 read/write with granule write mask, port 1 read-only,
// optional zero-fill after reset and selectable port-1 read-during-write result.
module sram_1rw1r_wmask #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int WMASK_WIDTH   = 4,
    parameter int INIT_ON_RESET = 1,
    parameter int RDW_MODE      = 0,
    parameter int VERBOSE       = 0
) (
    input logic               clk0,
    input logic               rstb0,
    sram_1rw1r_wmask_if.slave bus
);
    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int GRAN      = DATA_WIDTH / WMASK_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_mask
        $error("DATA_WIDTH must be a multiple of WMASK_WIDTH");
    end
    if (VERBOSE > 1) begin : g_bad_verbose
        $error("VERBOSE must be 0 or 1");
    end

    typedef enum logic {
        ST_READY = 1'b0,
        ST_INIT  = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   init_cnt;
    logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];
    logic                    rd0, wr0, rd1, collide, mem_we;
    logic [DATA_WIDTH-1:0]   bit_mask, merged, mem_wd;
    logic [ADDR_WIDTH-1:0]   mem_wa;

    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < WMASK_WIDTH; i++) begin
            bit_mask[i*GRAN +: GRAN] = {GRAN{bus.wmask0[i]}};
        end
    end

    // Reset dominates: the registered ready0 may still be high on the reset edge.
    assign rd0     = rstb0 & bus.ready0 & ~bus.csb0 & bus.web0;
    assign wr0     = rstb0 & bus.ready0 & ~bus.csb0 & ~bus.web0;
    assign rd1     = rstb0 & bus.ready0 & ~bus.csb1;
    assign collide = wr0 & rd1 & (bus.addr0 == bus.addr1);
    assign merged  = (mem[bus.addr0] & ~bit_mask) | (bus.din0 & bit_mask);

    always_comb begin
        mem_we = 1'b0;
        mem_wa = bus.addr0;
        mem_wd = merged;
        if (rstb0 && state == ST_INIT) begin
            mem_we = 1'b1;
            mem_wa = init_cnt;
            mem_wd = '0;
        end else if (wr0 && (|bus.wmask0)) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk0) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clk0) begin
        if (!rstb0) begin
            state       <= (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
            init_cnt    <= '0;
            bus.ready0  <= 1'b0;
            bus.dout0   <= '0;
            bus.dout1   <= '0;
            bus.dvalid0 <= 1'b0;
            bus.dvalid1 <= 1'b0;
        end else begin
            bus.dvalid0 <= rd0;
            bus.dvalid1 <= rd1;
            if (rd0) bus.dout0 <= mem[bus.addr0];
            // mem[] still holds the pre-write word here; RDW_MODE 1 forwards the merge.
            if (rd1) bus.dout1 <= (RDW_MODE != 0 && collide) ? merged : mem[bus.addr1];
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == LAST_ADDR) begin
                        state      <= ST_READY;
                        bus.ready0 <= 1'b1;
                    end
                end
                ST_READY: bus.ready0 <= 1'b1;
                default:  state <= ST_READY;
            endcase
        end
    end

    assign bus.state_dbg = (state == ST_INIT);
endmodule

// File: tb/tb_sram_1rw1r_wmask.sv
// Bench for sram_1rw1r_wmask: two instances (old-data and new-data read-during-write) share one
// stimulus stream and are checked every cycle against an array-based reference model.
module tb_sram_1rw1r_wmask;
  logic clk0;
  logic rstb0;

  sram_1rw1r_wmask_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WMASK_WIDTH(4)) bus_a ();
  sram_1rw1r_wmask_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WMASK_WIDTH(4)) bus_b ();

  sram_1rw1r_wmask #(.RDW_MODE(0)) dut_a (.clk0(clk0), .rstb0(rstb0), .bus(bus_a.slave));
  sram_1rw1r_wmask #(.RDW_MODE(1)) dut_b (.clk0(clk0), .rstb0(rstb0), .bus(bus_b.slave));

  assign bus_b.csb0   = bus_a.csb0;
  assign bus_b.web0   = bus_a.web0;
  assign bus_b.wmask0 = bus_a.wmask0;
  assign bus_b.addr0  = bus_a.addr0;
  assign bus_b.din0   = bus_a.din0;
  assign bus_b.csb1   = bus_a.csb1;
  assign bus_b.addr1  = bus_a.addr1;

  // ---------------- clock ----------------
  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] model_mem [256];
  logic [31:0] exp_q [$];
  int          rel_edges;
  bit          m_ready;
  bit          armed;
  logic [31:0] hold0, hold1a, hold1b;
  int          n_cmp, n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] expand(input logic [3:0] m);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < 4; i++) if (m[i]) r = r | (32'hFF << (8 * i));
    return r;
  endfunction

  // Advance one clock edge: predict the edge from the driven command, then compare both DUTs.
  task automatic tick();
    bit acc, rd0, wr0, rd1, col;
    logic [31:0] old0, old1, mrg;
    acc  = m_ready && rstb0;
    rd0  = acc && !bus_a.csb0 && bus_a.web0;
    wr0  = acc && !bus_a.csb0 && !bus_a.web0;
    rd1  = acc && !bus_a.csb1;
    old0 = model_mem[bus_a.addr0];
    old1 = model_mem[bus_a.addr1];
    mrg  = (old0 & ~expand(bus_a.wmask0)) | (bus_a.din0 & expand(bus_a.wmask0));
    col  = wr0 && rd1 && (bus_a.addr0 == bus_a.addr1);
    if (!rstb0) begin
      rel_edges = 0;
      m_ready   = 1'b0;
      hold0 = 32'h0; hold1a = 32'h0; hold1b = 32'h0;
      exp_q.delete();
      armed = 1'b1;
    end else begin
      rel_edges++;
      if (rd0) exp_q.push_back(old0);
      if (rd1) begin
        hold1a = old1;
        hold1b = col ? mrg : old1;
      end
      if (wr0) model_mem[bus_a.addr0] = mrg;
      if (rel_edges == 256) begin
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
        m_ready = 1'b1;
      end
    end
    @(posedge clk0);
    #1;
    if (!armed) return;
    if (rd0 && exp_q.size() > 0) hold0 = exp_q.pop_front();
    check("ready_a",   {31'h0, bus_a.ready0},  {31'h0, m_ready});
    check("ready_b",   {31'h0, bus_b.ready0},  {31'h0, m_ready});
    check("dvalid0_a", {31'h0, bus_a.dvalid0}, {31'h0, rd0});
    check("dvalid1_a", {31'h0, bus_a.dvalid1}, {31'h0, rd1});
    check("dvalid1_b", {31'h0, bus_b.dvalid1}, {31'h0, rd1});
    check("dout0_a",   bus_a.dout0, hold0);
    check("dout1_a",   bus_a.dout1, hold1a);
    check("dout1_b",   bus_b.dout1, hold1b);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic csb0, input logic web0, input logic [3:0] wm,
                       input logic [7:0] a0, input logic [31:0] d0,
                       input logic csb1, input logic [7:0] a1);
    bus_a.csb0 = csb0; bus_a.web0 = web0; bus_a.wmask0 = wm;
    bus_a.addr0 = a0;  bus_a.din0 = d0;
    bus_a.csb1 = csb1; bus_a.addr1 = a1;
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b1, 8'h00);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        csb0, web0;
    logic [3:0]  wm;
    logic [7:0]  a0;
    logic [31:0] d0;
    logic        csb1;
    logic [7:0]  a1;
    bit          c0;
    logic [31:0] e0;
    bit          c1;
    logic [31:0] e1a, e1b;
  } vec_t;

  vec_t vecs [$];

  initial begin
    int edges;
    n_cmp = 0; n_bad = 0; armed = 1'b0; m_ready = 1'b0; rel_edges = 0;
    hold0 = 32'h0; hold1a = 32'h0; hold1b = 32'h0;
    for (int i = 0; i < 256; i++) model_mem[i] = 32'hx;
    idle();
    rstb0 = 1'b0;

    // Vectors: {csb0, web0, mask, addr0, din0, csb1, addr1, chk0, exp dout0, chk1, exp dout1 old/new}
    vecs.push_back('{1'b0, 1'b0, 4'hF, 8'h10, 32'hDEADBEEF, 1'b1, 8'h00, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 4'h5, 8'h10, 32'h11223344, 1'b1, 8'h00, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 4'h0, 8'h10, 32'h0,        1'b1, 8'h00, 1'b1, 32'hDE22BE44, 1'b0, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 4'hF, 8'h20, 32'hA5A5A5A5, 1'b0, 8'h20, 1'b0, 32'h0, 1'b1, 32'h0, 32'hA5A5A5A5});
    vecs.push_back('{1'b0, 1'b1, 4'h0, 8'h20, 32'h0,        1'b0, 8'h10, 1'b1, 32'hA5A5A5A5, 1'b1, 32'hDE22BE44, 32'hDE22BE44});
    vecs.push_back('{1'b0, 1'b0, 4'h0, 8'h30, 32'hFFFFFFFF, 1'b1, 8'h00, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 4'h0, 8'h30, 32'h0,        1'b0, 8'h30, 1'b1, 32'h0, 1'b1, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 1'b0, 4'h8, 8'h40, 32'h12345678, 1'b0, 8'h40, 1'b0, 32'h0, 1'b1, 32'h0, 32'h12000000});
    vecs.push_back('{1'b1, 1'b1, 4'h0, 8'h40, 32'h0,        1'b0, 8'h40, 1'b1, 32'h0, 1'b1, 32'h12000000, 32'h12000000});

    // Reset held low for two edges, then the zero-fill runs for 256 edges.
    tick(); tick();
    check("reset_ready", {31'h0, bus_a.ready0}, 32'h0);
    check("reset_dout1", bus_a.dout1, 32'h0);
    rstb0 = 1'b1;
    // Writes and reads issued during the fill must be ignored.
    for (int i = 0; i < 255; i++) begin
      if (i < 8) drive(1'b0, 1'b0, 4'hF, 8'h80, 32'hFFFFFFFF, 1'b0, 8'h80);
      else idle();
      tick();
    end
    idle();
    tick();
    check("ready_at_256", {31'h0, bus_a.ready0}, 32'h1);

    drive(1'b0, 1'b1, 4'h0, 8'h80, 32'h0, 1'b0, 8'hFF);
    tick();
    check("read80_after_init", bus_a.dout0, 32'h0);
    check("read_ff_dout1", bus_a.dout1, 32'h0);
    check("read_ff_dvalid1", {31'h0, bus_a.dvalid1}, 32'h1);

    foreach (vecs[k]) begin
      drive(vecs[k].csb0, vecs[k].web0, vecs[k].wm, vecs[k].a0, vecs[k].d0, vecs[k].csb1, vecs[k].a1);
      tick();
      if (vecs[k].c0) check($sformatf("vec%0d_dout0", k), bus_a.dout0, vecs[k].e0);
      if (vecs[k].c1) begin
        check($sformatf("vec%0d_dout1_old", k), bus_a.dout1, vecs[k].e1a);
        check($sformatf("vec%0d_dout1_new", k), bus_b.dout1, vecs[k].e1b);
      end
    end
    idle();
    tick();
    check("idle_hold_dout0", bus_a.dout0, 32'h0);

    // Both ports reading distinct addresses back to back.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 4'hF, 8'(8'h50 + i), 32'($urandom), 1'b1, 8'h00);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 4'h0, 8'(8'h50 + i), 32'h0, 1'b0, 8'(8'h5F - i));
      tick();
    end

    // Randomized traffic on a narrow address window so collisions are frequent.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            8'($urandom_range(0, 7)), 32'($urandom), 1'($urandom_range(0, 3) == 0),
            8'($urandom_range(0, 7)));
      tick();
    end

    // Reset part-way through the fill restarts it from the beginning.
    idle();
    rstb0 = 1'b0;
    tick();
    rstb0 = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    rstb0 = 1'b0;
    tick();
    rstb0 = 1'b1;
    edges = 0;
    while (bus_a.ready0 !== 1'b1 && edges < 400) begin
      tick();
      edges++;
    end
    check("init_restart_edges", 32'(edges), 32'd256);
    drive(1'b0, 1'b1, 4'h0, 8'h03, 32'h0, 1'b0, 8'h05);
    tick();
    check("post_restart_read", bus_a.dout0 | bus_a.dout1, 32'h0);

    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            8'($urandom_range(0, 255)), 32'($urandom), 1'($urandom_range(0, 3) == 0),
            8'($urandom_range(0, 255)));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
